// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler for the 32x32 register file: round-robin between ALU and LSU writeback,
// one registered write per cycle, x0 writes dropped and counted.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DROP_CNT_W = 8,
  parameter int FIRST_TIE  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Hold,
  input  logic                  Alu_valid,
  input  logic [4:0]            Alu_rd,
  input  logic [DATA_W-1:0]     Alu_data,
  output logic                  Alu_ready,
  input  logic                  Lsu_valid,
  input  logic [4:0]            Lsu_rd,
  input  logic [DATA_W-1:0]     Lsu_data,
  output logic                  Lsu_ready,
  output logic [5:0]            A3,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  WE,
  output logic [31:0]           Busy_mask,
  output logic [DROP_CNT_W-1:0] Drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

  // r_prio_lsu=1 means the LSU wins the next tie (ALU was granted most recently)
  logic                  r_prio_lsu;
  logic                  r_we;
  logic [5:0]            r_a3;
  logic [DATA_W-1:0]     r_wdata;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_gnt_alu;
  logic                  w_gnt_lsu;
  logic                  w_gnt;
  logic [4:0]            w_sel_rd;
  logic [DATA_W-1:0]     w_sel_data;
  logic [31:0]           w_busy;

  // Grant decision and write-source selection
  always_comb begin
    w_gnt_alu  = 1'b0;
    w_gnt_lsu  = 1'b0;
    w_sel_rd   = 5'd0;
    w_sel_data = {DATA_W{1'b0}};
    if (Rst_n && !Hold) begin
      w_gnt_alu = Alu_valid && (!Lsu_valid || !r_prio_lsu);
      w_gnt_lsu = Lsu_valid && (!Alu_valid || r_prio_lsu);
    end else begin
      w_gnt_alu = 1'b0;
      w_gnt_lsu = 1'b0;
    end
    if (w_gnt_lsu) begin
      w_sel_rd   = Lsu_rd;
      w_sel_data = Lsu_data;
    end else begin
      w_sel_rd   = Alu_rd;
      w_sel_data = Alu_data;
    end
    w_gnt = w_gnt_alu || w_gnt_lsu;
  end

  // Output stage, x0 drop counter and round-robin pointer
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_we       <= 1'b0;
      r_a3       <= 6'd0;
      r_wdata    <= {DATA_W{1'b0}};
      r_drop_cnt <= {DROP_CNT_W{1'b0}};
      r_prio_lsu <= (FIRST_TIE != 0);
    end else begin
      r_we <= w_gnt && (w_sel_rd != 5'd0);
      if (w_gnt && (w_sel_rd != 5'd0)) begin
        r_a3    <= {1'b0, w_sel_rd};
        r_wdata <= w_sel_data;
      end else begin
        r_a3    <= r_a3;
        r_wdata <= r_wdata;
      end
      if (w_gnt && (w_sel_rd == 5'd0) && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + DROP_ONE;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      if (w_gnt_alu) begin
        r_prio_lsu <= 1'b1;
      end else if (w_gnt_lsu) begin
        r_prio_lsu <= 1'b0;
      end else begin
        r_prio_lsu <= r_prio_lsu;
      end
    end
  end

  // One-hot of the register currently being written
  always_comb begin
    w_busy = 32'd0;
    if (r_we) begin
      w_busy[r_a3[4:0]] = 1'b1;
    end else begin
      w_busy = 32'd0;
    end
  end

  assign Alu_ready = w_gnt_alu;
  assign Lsu_ready = w_gnt_lsu;
  assign WE        = r_we;
  assign A3        = r_a3;
  assign WriteData = r_wdata;
  assign Drop_cnt  = r_drop_cnt;
  assign Busy_mask = w_busy;

endmodule
